alu_cmd_sequencer: RTL and testbench
====================================

# alu_cmd_sequencer

Sequential front-end that drives the team's combinational 4-function ALU from a valid/ready command stream. It registers operands and function, presents them on the ALU input port, and captures the ALU result one cycle later. It returns the result on a valid/ready result stream and keeps an accumulator that can feed back as operand B. It sits between a command source (switch/key controller or test FSM) and the ALU, which is instantiated beside it in the parent.

## Interface
- N, 4, operand width; result width is 2N.
- Clock  in  1  single clock, all state updates on rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_func  in  2  function code: 00 add, 01 OR-reduce of {A,B}, 10 AND-reduce of {A,B}, 11 concat {A,B}.
- cmd_a  in  N  operand A.
- cmd_b  in  N  operand B, used when cmd_use_acc=0.
- cmd_use_acc  in  1  1: B = acc[N-1:0].
- acc_clear  in  1  synchronous accumulator clear, honoured only in IDLE.
- alu_a  out  N  to ALU operand A.
- alu_b  out  N  to ALU operand B.
- alu_func  out  2  to ALU function select.
- alu_result  in  2N  from ALU output (combinational in alu_a/alu_b/alu_func).
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  2N  captured result.
- acc  out  2N  accumulator, last captured result.
- op_count  out  8  completed-operation counter, wraps 8'hFF -> 8'h00.

## Operation
- States: IDLE, EXEC, DONE (2-bit encoding).
- IDLE: cmd_ready=1. acc_clear=1 sets acc to 0 this cycle. On cmd_valid: latch cmd_a, cmd_func, and B (acc[N-1:0] if cmd_use_acc, else cmd_b) into the operand registers, then go to EXEC. If acc_clear and accept coincide, the clear takes precedence for B selection: B = 0 when cmd_use_acc=1.
- EXEC: one cycle. alu_a/alu_b/alu_func are driven from the operand registers, so they are stable for the whole cycle. At the end of the cycle, capture alu_result into res_data and acc, increment op_count, then go to DONE.
- DONE: res_valid=1. res_data is held. On res_ready, go to IDLE. cmd_ready=0; cmd_valid is ignored.
- Outside the capture edge, acc changes only via acc_clear in IDLE.
- alu_* outputs always reflect the operand registers and hold their last values in IDLE/DONE.
- Reset values: state IDLE, cmd_ready=1 after reset release, res_valid=0, res_data=0, acc=0, op_count=0, alu_a=0, alu_b=0, alu_func=00.

## Timing
- Command accepted at edge k (cmd_valid & cmd_ready).
- Operands appear on alu_* after edge k.
- Result captured at edge k+1. res_valid is high after edge k+1.
- Latency: 2 cycles from accept to res_valid.
- Peak throughput: one command per 3 cycles when res_ready is held high (IDLE->EXEC->DONE->IDLE).
- Handshake: res_valid, once high, stays high with res_data stable until res_ready is sampled high. There is no combinational path from res_ready to cmd_ready.
- Resetn low at any time, including during EXEC or DONE: all registers go to their reset values immediately. Any in-flight result is discarded.

## Structure
- Shared package holds:
  - function code constants (FN_ADD, FN_OR, FN_AND, FN_CAT)
  - state encoding (ST_IDLE, ST_EXEC, ST_DONE)
  - default N
- No sub-module. The ALU is instantiated by the parent and wired to the alu_* ports.
- The bench instantiates sequencer and ALU together.

## Test plan
- Reset: hold Resetn low mid-run -> res_valid=0, acc=8'h00, op_count=0, alu_func=00. After release, cmd_ready=1.
- Add: a=4'hA, b=4'h7, func 00, res_ready=1 -> res_valid exactly 2 cycles after accept, res_data=8'h11, acc=8'h11, op_count=1.
- Feedback: acc=8'h11, then a=4'h3, use_acc=1, func 00 -> alu_b=4'h1, res_data=8'h04. Same command with acc_clear=1 in the accept cycle -> alu_b=4'h0, res_data=8'h03.
- Function coverage:
  - concat a=4'hC, b=4'h5 -> 8'hC5
  - OR a=0, b=0 -> 8'h00
  - OR a=0, b=4'h2 -> 8'h01
  - AND a=4'hF, b=4'hF -> 8'h01
  - AND a=4'hF, b=4'hE -> 8'h00
- Backpressure: res_ready low 5 cycles in DONE, with cmd_valid pulsing -> res_valid and res_data held, cmd_ready=0, no extra op_count increment. A single-cycle res_ready -> IDLE next cycle.
- Counter wrap: 256 back-to-back adds -> op_count returns to 8'h00, with no dropped or duplicated results.

Source files
------------

// File: rtl/alu_cmd_sequencer_pkg.sv
// alu_cmd_sequencer_pkg
// Shared definitions for the ALU command sequencer and its neighbours:
// default operand width, ALU function codes and the sequencer state type.
package alu_cmd_sequencer_pkg;

    localparam int unsigned N_DEFAULT = 4;

    // ALU function select codes
    localparam logic [1:0] FN_ADD = 2'b00;  // A + B, zero-extended to 2N
    localparam logic [1:0] FN_OR  = 2'b01;  // |{A,B}, zero-extended
    localparam logic [1:0] FN_AND = 2'b10;  // &{A,B}, zero-extended
    localparam logic [1:0] FN_CAT = 2'b11;  // {A,B}

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Sequential front-end for the combinational 4-function ALU. Accepts a
// command on a valid/ready stream, registers operands onto the ALU input
// port, captures the ALU result one cycle later and returns it on a
// valid/ready result stream. The last captured result is kept as an
// accumulator whose low half can be fed back as operand B.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   cmd_valid/ready command handshake
//   cmd_func        function code (see package FN_*)
//   cmd_a, cmd_b    operands; cmd_use_acc selects acc[N-1:0] instead of cmd_b
//   acc_clear       synchronous accumulator clear, honoured only in IDLE
//   alu_a/b/func    registered operands to the external ALU
//   alu_result      combinational result from the external ALU
//   res_valid/ready result handshake, res_data captured result
//   acc             accumulator (last captured result)
//   op_count        completed-operation counter, wraps at 8 bits
module alu_cmd_sequencer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_func,
    input  logic [N-1:0]     cmd_a,
    input  logic [N-1:0]     cmd_b,
    input  logic             cmd_use_acc,
    input  logic             acc_clear,
    output logic [N-1:0]     alu_a,
    output logic [N-1:0]     alu_b,
    output logic [1:0]       alu_func,
    input  logic [2*N-1:0]   alu_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [2*N-1:0]   res_data,
    output logic [2*N-1:0]   acc,
    output logic [7:0]       op_count
);

    state_t         state;
    state_t         state_next;
    logic           accept;
    logic           capture;
    logic           clear_acc;
    logic [N-1:0]   b_sel;
    logic [N-1:0]   op_a;
    logic [N-1:0]   op_b;
    logic [1:0]     op_func;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        res_valid  = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        clear_acc  = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                clear_acc = acc_clear;
                if (cmd_valid) begin
                    accept     = 1'b1;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                capture    = 1'b1;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A clear in the accept cycle wins over feedback: B sees the cleared value.
    always_comb begin
        b_sel = cmd_b;
        if (cmd_use_acc) begin
            b_sel = clear_acc ? '0 : acc[N-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a     <= '0;
            op_b     <= '0;
            op_func  <= FN_ADD;
            res_data <= '0;
            acc      <= '0;
            op_count <= '0;
        end else begin
            if (accept) begin
                op_a    <= cmd_a;
                op_b    <= b_sel;
                op_func <= cmd_func;
            end
            if (capture) begin
                res_data <= alu_result;
                acc      <= alu_result;
                op_count <= op_count + 8'd1;
            end else if (clear_acc) begin
                acc <= '0;
            end
        end
    end

    assign alu_a    = op_a;
    assign alu_b    = op_b;
    assign alu_func = op_func;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer
// Bench for alu_cmd_sequencer: instantiates the sequencer beside a
// behavioural 4-function ALU and checks directed and random commands
// against a reference model of results, accumulator and counter.
module tb_alu_cmd_sequencer;

    localparam int unsigned N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [1:0]     cmd_func;
    logic [N-1:0]   cmd_a;
    logic [N-1:0]   cmd_b;
    logic           cmd_use_acc;
    logic           acc_clear;
    logic [N-1:0]   alu_a;
    logic [N-1:0]   alu_b;
    logic [1:0]     alu_func;
    logic [2*N-1:0] alu_result;
    logic           res_valid;
    logic           res_ready;
    logic [2*N-1:0] res_data;
    logic [2*N-1:0] acc;
    logic [7:0]     op_count;

    int tests = 0;
    int fails = 0;

    // reference state
    logic [7:0] m_acc;
    logic [7:0] m_count;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_func   (cmd_func),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_use_acc(cmd_use_acc),
        .acc_clear  (acc_clear),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_func   (alu_func),
        .alu_result (alu_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .acc        (acc),
        .op_count   (op_count)
    );

    // ALU placed beside the sequencer, as the parent would do
    always_comb begin
        alu_result = '0;
        case (alu_func)
            2'b00:   alu_result = {4'b0, alu_a} + {4'b0, alu_b};
            2'b01:   alu_result = {7'b0, |{alu_a, alu_b}};
            2'b10:   alu_result = {7'b0, &{alu_a, alu_b}};
            default: alu_result = {alu_a, alu_b};
        endcase
    end

    function automatic logic [7:0] ref_alu(input int a, input int b, input int f);
        case (f)
            0:       return 8'(a + b);
            1:       return ((a != 0) || (b != 0)) ? 8'd1 : 8'd0;
            2:       return ((a == 15) && (b == 15)) ? 8'd1 : 8'd0;
            default: return 8'(a * 16 + b);
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts at a falling edge with the sequencer idle. Ends one cycle after
    // DONE is entered: back in IDLE if rr=1, still in DONE if rr=0.
    task automatic run_cmd(input logic [3:0] a, input logic [3:0] b, input logic [1:0] f,
                           input logic use_acc, input logic clr, input logic rr,
                           input int spec_res);
        logic [3:0] b_eff;
        logic [7:0] r;
        check("cmd_ready_idle", {7'b0, cmd_ready}, 8'd1);
        cmd_valid   = 1'b1;
        cmd_a       = a;
        cmd_b       = b;
        cmd_func    = f;
        cmd_use_acc = use_acc;
        acc_clear   = clr;
        res_ready   = rr;
        if (clr) m_acc = 8'd0;
        b_eff = use_acc ? m_acc[3:0] : b;
        r = ref_alu(int'(a), int'(b_eff), int'(f));
        @(negedge clk);
        cmd_valid = 1'b0;
        acc_clear = 1'b0;
        cmd_a     = 4'($urandom);
        cmd_b     = 4'($urandom);
        cmd_func  = 2'($urandom);
        check("alu_a", {4'b0, alu_a}, {4'b0, a});
        check("alu_b", {4'b0, alu_b}, {4'b0, b_eff});
        check("alu_func", {6'b0, alu_func}, {6'b0, f});
        check("res_valid_exec", {7'b0, res_valid}, 8'd0);
        check("cmd_ready_exec", {7'b0, cmd_ready}, 8'd0);
        @(negedge clk);
        m_acc   = r;
        m_count = m_count + 8'd1;
        check("res_valid_done", {7'b0, res_valid}, 8'd1);
        check("res_data", res_data, r);
        check("acc", acc, r);
        check("op_count", op_count, m_count);
        if (spec_res >= 0) check("res_data_spec", res_data, 8'(spec_res));
        if (rr) begin
            @(negedge clk);
            check("res_valid_back_idle", {7'b0, res_valid}, 8'd0);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_func    = 2'b00;
        cmd_a       = '0;
        cmd_b       = '0;
        cmd_use_acc = 1'b0;
        acc_clear   = 1'b0;
        res_ready   = 1'b0;
        m_acc       = 8'd0;
        m_count     = 8'd0;

        // reset values
        repeat (2) @(negedge clk);
        check("rst_res_valid", {7'b0, res_valid}, 8'd0);
        check("rst_res_data", res_data, 8'd0);
        check("rst_acc", acc, 8'd0);
        check("rst_op_count", op_count, 8'd0);
        check("rst_alu_a", {4'b0, alu_a}, 8'd0);
        check("rst_alu_b", {4'b0, alu_b}, 8'd0);
        check("rst_alu_func", {6'b0, alu_func}, 8'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", {7'b0, cmd_ready}, 8'd1);

        // directed functions
        run_cmd(4'hA, 4'h7, 2'b00, 1'b0, 1'b0, 1'b1, 'h11);
        check("add_op_count", op_count, 8'd1);
        run_cmd(4'h3, 4'h9, 2'b00, 1'b1, 1'b0, 1'b1, 'h04);
        run_cmd(4'h3, 4'h9, 2'b00, 1'b1, 1'b1, 1'b1, 'h03);
        run_cmd(4'hC, 4'h5, 2'b11, 1'b0, 1'b0, 1'b1, 'hC5);
        run_cmd(4'h0, 4'h0, 2'b01, 1'b0, 1'b0, 1'b1, 'h00);
        run_cmd(4'h0, 4'h2, 2'b01, 1'b0, 1'b0, 1'b1, 'h01);
        run_cmd(4'hF, 4'hF, 2'b10, 1'b0, 1'b0, 1'b1, 'h01);
        run_cmd(4'hF, 4'hE, 2'b10, 1'b0, 1'b0, 1'b1, 'h00);

        // backpressure in DONE with cmd_valid pulsing
        run_cmd(4'h5, 4'h6, 2'b00, 1'b0, 1'b0, 1'b0, 'h0B);
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'($urandom);
            cmd_a     = 4'($urandom);
            cmd_b     = 4'($urandom);
            @(negedge clk);
            check("bp_res_valid", {7'b0, res_valid}, 8'd1);
            check("bp_res_data", res_data, m_acc);
            check("bp_acc", acc, m_acc);
            check("bp_cmd_ready", {7'b0, cmd_ready}, 8'd0);
            check("bp_op_count", op_count, m_count);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("bp_release_valid", {7'b0, res_valid}, 8'd0);
        check("bp_release_ready", {7'b0, cmd_ready}, 8'd1);
        @(negedge clk);
        check("bp_idle_op_count", op_count, m_count);
        check("bp_idle_acc", acc, m_acc);

        // random mix of functions, feedback and clears
        for (int i = 0; i < 40; i++) begin
            run_cmd(4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom),
                    ($urandom_range(0, 3) == 0), 1'b1, -1);
        end

        // reset asserted while a command is executing
        cmd_valid = 1'b1;
        cmd_a     = 4'h9;
        cmd_b     = 4'h4;
        cmd_func  = 2'b11;
        cmd_use_acc = 1'b0;
        res_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        m_acc   = 8'd0;
        m_count = 8'd0;
        check("midrst_res_valid", {7'b0, res_valid}, 8'd0);
        check("midrst_acc", acc, 8'd0);
        check("midrst_op_count", op_count, 8'd0);
        check("midrst_alu_func", {6'b0, alu_func}, 8'd0);
        check("midrst_alu_a", {4'b0, alu_a}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_cmd_ready", {7'b0, cmd_ready}, 8'd1);
        check("midrst_discard", {7'b0, res_valid}, 8'd0);
        check("midrst_res_data", res_data, 8'd0);

        // 256 back-to-back adds wrap the counter
        for (int i = 0; i < 256; i++) begin
            run_cmd(4'($urandom), 4'($urandom), 2'b00, 1'($urandom), 1'b0, 1'b1, -1);
        end
        check("wrap_op_count", op_count, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
